// File: rtl/kv_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kv_cache_pkg
// Purpose  : Shared types and default sizing for the KV cache controller.
//            Provides the controller state enum and the default depth/width
//            constants used by the interface and the top module.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package kv_cache_pkg;

    localparam int c_max_seq_default  = 256;
    localparam int c_head_dim_default = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/kv_cache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : kv_cache_ctrl_if
// Purpose  : Bundles the append stream, readback stream, status and RAM-side
//            signals of the KV cache controller.
// Modports : slave  - the controller (kv_cache_ctrl)
//            master - the environment (datapaths + kv_ram)
// Revision : 1.0 - initial release
// ============================================================================
interface kv_cache_ctrl_if
    import kv_cache_pkg::*;
#(
    parameter int MAX_SEQ  = c_max_seq_default,
    parameter int HEAD_DIM = c_head_dim_default
);
    localparam int AW  = $clog2(MAX_SEQ * HEAD_DIM);
    localparam int SLW = $clog2(MAX_SEQ + 1);

    logic           clear_i;
    logic           wr_valid_i;
    logic [7:0]     wr_data_i;
    logic           wr_ready_o;
    logic           rd_start_i;
    logic           rd_valid_o;
    logic [7:0]     rd_data_o;
    logic           rd_last_o;
    logic           rd_ready_i;
    logic           rd_done_o;
    logic [SLW-1:0] seq_len_o;
    logic           full_o;
    logic           busy_o;
    logic [AW-1:0]  ram_addr_o;
    logic           ram_we_o;
    logic [7:0]     ram_wdata_o;
    logic [7:0]     ram_rdata_i;

    modport slave (
        input  clear_i, wr_valid_i, wr_data_i, rd_start_i, rd_ready_i, ram_rdata_i,
        output wr_ready_o, rd_valid_o, rd_data_o, rd_last_o, rd_done_o,
               seq_len_o, full_o, busy_o, ram_addr_o, ram_we_o, ram_wdata_o
    );

    modport master (
        output clear_i, wr_valid_i, wr_data_i, rd_start_i, rd_ready_i, ram_rdata_i,
        input  wr_ready_o, rd_valid_o, rd_data_o, rd_last_o, rd_done_o,
               seq_len_o, full_o, busy_o, ram_addr_o, ram_we_o, ram_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/kv_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : kv_rd_skid
// Purpose  : 2-entry output buffer for the readback stream. Head entry is
//            presented on out_* and held until popped.
// Ports    : clk_i, rst_ni         - clock, async active-low reset
//            in_valid/data/last    - push side (caller guarantees space)
//            out_valid/data/last   - pop side, out_ready consumes
//            occ                   - current occupancy 0..2
// Revision : 1.0 - initial release
// ============================================================================
module kv_rd_skid (
    input  wire logic       clk_i,
    input  wire logic       rst_ni,
    input  wire logic       in_valid,
    input  wire logic [7:0] in_data,
    input  wire logic       in_last,
    output logic            out_valid,
    output logic [7:0]      out_data,
    output logic            out_last,
    input  wire logic       out_ready,
    output logic [1:0]      occ
);
    logic [1:0] r_cnt;
    logic [7:0] r_data0;
    logic [7:0] r_data1;
    logic       r_last0;
    logic       r_last1;
    logic       w_pop;

    assign out_valid = (r_cnt != 2'd0);
    assign w_pop     = out_valid & out_ready;
    assign out_data  = r_data0;
    assign out_last  = r_last0 & out_valid;
    assign occ       = r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= 2'd0;
            r_data0 <= 8'd0;
            r_data1 <= 8'd0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
        end else begin
            case ({in_valid, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_data0 <= in_data;
                        r_last0 <= in_last;
                    end else begin
                        r_data1 <= in_data;
                        r_last1 <= in_last;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_cnt   <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: the new byte lands behind whatever remains.
                    if (r_cnt == 2'd1) begin
                        r_data0 <= in_data;
                        r_last0 <= in_last;
                    end else begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= in_data;
                        r_last1 <= in_last;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/kv_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kv_cache_ctrl
// Purpose  : Sequencing controller for a single-port KV cache BRAM. Appends
//            HEAD_DIM-byte vectors, streams all stored vectors back on
//            request and arbitrates the single RAM port between the two.
// Ports    : clk_i  - clock
//            rst_ni - asynchronous active-low reset
//            bus    - kv_cache_ctrl_if.slave (append, readback, status, RAM)
// Revision : 1.0 - initial release
// ============================================================================
module kv_cache_ctrl
    import kv_cache_pkg::*;
#(
    parameter int MAX_SEQ  = c_max_seq_default,
    parameter int HEAD_DIM = c_head_dim_default
) (
    input  wire logic      clk_i,
    input  wire logic      rst_ni,
    kv_cache_ctrl_if.slave bus
);
    localparam int AW  = $clog2(MAX_SEQ * HEAD_DIM);
    localparam int SLW = $clog2(MAX_SEQ + 1);
    localparam int TW  = AW + 1;
    localparam int DW  = (HEAD_DIM > 1) ? $clog2(HEAD_DIM) : 1;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [SLW-1:0] r_seq_len;
    logic [DW-1:0]  r_wr_d;
    logic           r_rd_pend;
    logic [TW-1:0]  r_total;
    logic [TW-1:0]  r_rd_addr;
    logic           r_inflight;
    logic           r_inflight_last;

    logic           w_full;
    logic           w_rd_go;
    logic           w_clear;
    logic           w_wr_ready;
    logic           w_wr_acc;
    logic           w_wr_last;
    logic           w_issue;
    logic           w_pop;
    logic [TW-1:0]  w_wr_base;
    logic [TW-1:0]  w_wr_addr;
    logic [1:0]     w_occ;
    logic [2:0]     w_pipe;
    logic           w_sk_valid;
    logic           w_sk_last;
    logic [7:0]     w_sk_data;

    assign w_full    = (r_seq_len == SLW'(MAX_SEQ));
    // A pending read is serviced exactly like a fresh rd_start from IDLE.
    assign w_rd_go   = (r_state == ST_IDLE) && (bus.rd_start_i || r_rd_pend);
    assign w_clear   = (r_state == ST_IDLE) && bus.clear_i && !w_rd_go;
    // Gated by rst_ni so nothing is accepted or written while reset is held.
    // A clear also blocks a new vector so byte 0 never lands at a stale base.
    assign w_wr_ready = rst_ni && ((r_state == ST_WRITE) ||
                        ((r_state == ST_IDLE) && !w_full && !w_rd_go && !bus.clear_i));
    assign w_wr_acc  = w_wr_ready && bus.wr_valid_i;
    assign w_wr_last = (r_wr_d == DW'(HEAD_DIM - 1));
    assign w_wr_base = TW'(r_seq_len) * TW'(HEAD_DIM);
    assign w_wr_addr = w_wr_base + TW'(r_wr_d);

    // Space check uses occupancy after this cycle's pop so a steady
    // ready consumer sees one byte per cycle.
    assign w_pop   = w_sk_valid && bus.rd_ready_i;
    assign w_pipe  = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue = (r_state == ST_READ) && (r_rd_addr < r_total) && (w_pipe < 3'd2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        bus.ram_we_o    = 1'b0;
        bus.ram_addr_o  = '0;
        bus.ram_wdata_o = 8'd0;
        bus.rd_done_o   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_go) begin
                    w_state_nxt = ST_READ;
                end else if (w_wr_acc && !w_wr_last) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_wr_acc && w_wr_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                if ((r_total == '0) || (w_pop && w_sk_last)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.rd_done_o = 1'b1;
                w_state_nxt   = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_wr_acc) begin
            bus.ram_we_o    = 1'b1;
            bus.ram_addr_o  = w_wr_addr[AW-1:0];
            bus.ram_wdata_o = bus.wr_data_i;
        end else if (w_issue) begin
            bus.ram_addr_o  = r_rd_addr[AW-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_seq_len       <= '0;
            r_wr_d          <= '0;
            r_rd_pend       <= 1'b0;
            r_total         <= '0;
            r_rd_addr       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rd_addr == r_total - TW'(1));
            if (w_issue) begin
                r_rd_addr <= r_rd_addr + TW'(1);
            end
            if (w_rd_go) begin
                r_total   <= w_wr_base;
                r_rd_addr <= '0;
                r_rd_pend <= 1'b0;
            end else if (bus.rd_start_i && (r_state == ST_WRITE)) begin
                r_rd_pend <= 1'b1;
            end
            if (w_wr_acc) begin
                if (w_wr_last) begin
                    r_wr_d    <= '0;
                    r_seq_len <= r_seq_len + SLW'(1);
                end else begin
                    r_wr_d    <= r_wr_d + DW'(1);
                end
            end
            if (w_clear) begin
                r_seq_len <= '0;
            end
        end
    end

    kv_rd_skid u_skid (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid  (r_inflight),
        .in_data   (bus.ram_rdata_i),
        .in_last   (r_inflight_last),
        .out_valid (w_sk_valid),
        .out_data  (w_sk_data),
        .out_last  (w_sk_last),
        .out_ready (bus.rd_ready_i),
        .occ       (w_occ)
    );

    assign bus.wr_ready_o = w_wr_ready;
    assign bus.rd_valid_o = w_sk_valid;
    assign bus.rd_data_o  = w_sk_data;
    assign bus.rd_last_o  = w_sk_last;
    assign bus.seq_len_o  = r_seq_len;
    assign bus.full_o     = w_full;
    assign bus.busy_o     = (r_state != ST_IDLE) || r_rd_pend;

endmodule
`default_nettype wire

// File: doc/kv_cache_ctrl.md
Name: kv_cache_ctrl

Overview:
Sequencing controller for one single-port KV cache BRAM (8-bit data, 1-cycle registered read, write-first). Appends one HEAD_DIM-byte K or V vector per token from the projection datapath. On request, streams every stored vector back to the attention datapath. Arbitrates the single RAM port between the append and readback streams and tracks the sequence length.

Parameters:
MAX_SEQ, 256, maximum cached token positions
HEAD_DIM, 16, bytes per stored vector
AW, $clog2(MAX_SEQ*HEAD_DIM), RAM address width (derived, do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  reset seq_len to 0; honoured only in IDLE with no pending read
wr_valid_i  in  1  append byte valid
wr_data_i  in  8  append byte
wr_ready_o  out  1  append byte accepted when valid&&ready
rd_start_i  in  1  pulse: request full readback
rd_valid_o  out  1  readback byte valid
rd_data_o  out  8  readback byte
rd_last_o  out  1  final byte of readback, qualified by rd_valid_o
rd_ready_i  in  1  readback consumer ready
rd_done_o  out  1  one-cycle pulse when readback completes
seq_len_o  out  $clog2(MAX_SEQ+1)  completed vectors stored
full_o  out  1  seq_len_o==MAX_SEQ
busy_o  out  1  state!=IDLE or read pending
ram_addr_o  out  AW  to kv_ram address
ram_we_o  out  1  to kv_ram write enable
ram_wdata_o  out  8  to kv_ram write data
ram_rdata_i  in  8  from kv_ram registered read data

Behaviour:
- Reset (async, rst_ni=0): state IDLE, seq_len=0, pointers 0, read-pending=0, output buffer empty. All outputs 0, except ram_addr_o, which is also 0.
- Layout: address = pos*HEAD_DIM + d, d = byte index 0..HEAD_DIM-1.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - rd_start_i has priority over wr_valid_i in the same cycle.
  - rd_start_i → READ; snapshot total = seq_len*HEAD_DIM.
  - Otherwise wr_valid_i && !full → WRITE. First byte is accepted in this same cycle.
- WRITE:
  - wr_ready_o=1 while in WRITE, or in IDLE when !full and no read is starting.
  - Accepted byte drives ram_we_o=1, ram_addr_o=seq_len*HEAD_DIM+d, ram_wdata_o=wr_data_i combinationally; zero added latency.
  - After byte HEAD_DIM-1: seq_len++ the next cycle, return to IDLE.
  - A vector is never split. rd_start_i during WRITE sets read-pending, serviced from IDLE once the vector completes.
- READ:
  - Read address counter runs 0..total-1, with a 2-entry output buffer.
  - Issue a read (ram_we_o=0) only when buffer occupancy + in-flight reads < 2. This sustains 1 byte/cycle with rd_ready_i held high.
  - ram_rdata_i is captured one cycle after issue.
  - rd_last_o accompanies byte total-1.
  - wr_ready_o=0 throughout READ.
  - After the last byte is handshaken → DONE.
- DONE: rd_done_o=1 for one cycle → IDLE.
- total==0: READ → DONE with no rd_valid_o; rd_done_o pulses 2 cycles after rd_start_i.
- full: wr_ready_o=0 in IDLE; wr_valid_i is ignored; no RAM write.
- clear_i outside IDLE or with read pending: ignored. clear_i and rd_start_i in the same IDLE cycle: read taken, clear ignored.
- rd_start_i during READ/DONE: ignored (not queued).
- rd_valid_o, once high, holds data stable until rd_ready_i.
- Reset mid-operation: immediate return to reset state. Partially written vector is discarded (seq_len unchanged by it).

Decomposition:
- Package kv_cache_pkg: state enum (IDLE, WRITE, READ, DONE); default MAX_SEQ/HEAD_DIM constants.
- Sub-module kv_rd_skid: 2-entry output buffer with valid/ready and occupancy output.
- kv_ram is instantiated by the parent, not inside this block.

Test Plan:
- Append 16 bytes 0x00..0x0F, wr_valid_i high → 16 consecutive ram_we_o at addr 0..15; seq_len_o=1 the cycle after the last byte.
- Two vectors written, rd_start_i, rd_ready_i=1 → 32 bytes in address order, 1/cycle after 2-cycle startup; rd_last_o on byte 31; rd_done_o pulse once.
- Readback with rd_ready_i toggling 1,0,0,1 → no byte lost or duplicated; data held stable while stalled.
- rd_start_i at byte 5 of a write → write completes 16 bytes, then readback includes the new vector (seq_len=3 → 48 bytes).
- Fill to MAX_SEQ=256 → full_o=1, wr_ready_o=0; clear_i → seq_len_o=0, full_o=0.
- rd_start_i with seq_len=0 → no rd_valid_o, rd_done_o 2 cycles later; rst_ni low mid-write → all outputs 0, seq_len unchanged from before the vector.
